// File: rtl/alu_req_ctrl.sv
// rtl/alu_req_ctrl.sv - valid/ready request controller driving the 8-op ALU and returning its result
// Optional statistics counters enabled by defining ALU_REQ_CTRL_STATS_EN.
module alu_req_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MOD_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
`ifdef ALU_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_busy
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [2:0]       OP_MOD  = 3'b111;
  localparam logic [CNT_W-1:0] MOD_CNT = CNT_W'(MOD_WAIT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mod_start;
  logic             accept;
  logic             is_mod;
  logic             div_zero;

  assign req_ready = (state == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign is_mod    = (req_op == OP_MOD);
  assign div_zero  = is_mod && (req_b == '0);
  // The iterative mod unit restarts from its own reset, pulsed once as the op begins.
  assign alu_reset = reset || ((state == ST_WAIT) && mod_start);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = div_zero ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nx = ST_RESP;
      ST_RESP: if (resp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mod_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'b000;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (accept) begin
          alu_a     <= req_a;
          alu_b     <= req_b;
          alu_op    <= req_op;
          mod_start <= is_mod && !div_zero;
          cnt       <= (is_mod && !div_zero) ? MOD_CNT : '0;
          if (div_zero) begin
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b1;
          end
        end
        ST_WAIT: begin
          mod_start <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_valid <= 1'b1;
            resp_data  <= alu_result;
            resp_err   <= 1'b0;
          end
        end
        ST_RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALU_REQ_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops  <= '0;
      stat_busy <= '0;
    end else begin
      if (resp_valid && resp_ready && stat_ops != 16'hFFFF) stat_ops <= stat_ops + 1'b1;
      if (state != ST_IDLE && stat_busy != 16'hFFFF) stat_busy <= stat_busy + 1'b1;
    end
  end
`endif

endmodule
